// File: rtl/mul_div_seq.sv
// mul_div_seq
// Iterative RV32M multiply/divide unit for the execute stage. One radix-2
// step per clock, fixed latency for every operation so the pipeline control
// can stall for a known number of cycles.
//
// Ports
//   clk_i     clock for all state
//   rst_ni    asynchronous active-low reset
//   start_i   operation request, only honoured while idle
//   op_i      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a_i       rs1 operand, captured on an accepted start
//   b_i       rs2 operand, captured on an accepted start
//   kill_i    synchronous abort of an in-flight operation
//   busy_o    high while computing (CALC and FIX)
//   done_o    single-cycle pulse when result_o becomes valid
//   result_o  final value, held until the next completed operation

module mul_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                aSigned, bSigned, aNeg, bNeg, negIn;
  logic [XLEN-1:0]     aMag, bMag;
  logic [XLEN:0]       mulSum;
  logic [2*XLEN-1:0]   mulStep;
  logic [XLEN:0]       divTrial;
  logic                divQBit;
  logic [XLEN-1:0]     divDiff;
  logic [2*XLEN-1:0]   divStep;
  logic [2*XLEN-1:0]   prodFinal;
  logic [XLEN-1:0]     quotFinal, remFinal, fixWord;

  // Operand conditioning at accept time. Both datapaths work on magnitudes;
  // the sign of the final word is remembered in a single negate flag whose
  // meaning depends on which word the op selects. A zero divisor must not
  // flip the all-ones quotient, and the remainder always follows the
  // dividend, which makes REM by zero return a unchanged.
  always_comb begin
    aSigned = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    bSigned = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    aNeg    = aSigned && a_i[XLEN-1];
    bNeg    = bSigned && b_i[XLEN-1];
    aMag    = aNeg ? (~a_i + 1'b1) : a_i;
    bMag    = bNeg ? (~b_i + 1'b1) : b_i;
    if (op_i[2]) begin
      if (op_i[1]) begin
        negIn = aNeg;
      end else begin
        negIn = (aNeg ^ bNeg) && (b_i != '0);
      end
    end else begin
      negIn = aNeg ^ bNeg;
    end
  end

  // One iteration of each datapath. Multiply keeps the multiplier in the low
  // half of the accumulator and shifts the partial product in from the top.
  // Divide keeps remainder:dividend and shifts quotient bits in at the bottom;
  // the trial remainder needs one extra bit because the shifted value can
  // exceed XLEN bits before the subtract.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mulStep  = {mulSum, acc_q[XLEN-1:1]};
    divTrial = acc_q[2*XLEN-1:XLEN-1];
    divQBit  = (divTrial >= {1'b0, mcand_q});
    divDiff  = divTrial[XLEN-1:0] - mcand_q;
    divStep  = {(divQBit ? divDiff : divTrial[XLEN-1:0]), acc_q[XLEN-2:0], divQBit};
  end

  // Sign fix-up and word selection for the final result.
  always_comb begin
    prodFinal = neg_q ? (~acc_q + 1'b1) : acc_q;
    quotFinal = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    remFinal  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fixWord = prodFinal[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixWord = prodFinal[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixWord = quotFinal;
      default:                fixWord = remFinal;
    endcase
  end

  // Control FSM and datapath next-state. The counter exits CALC after
  // exactly XLEN steps, giving the same latency for every op.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          state_d = CALC;
          op_d    = op_i;
          neg_d   = negIn;
          cnt_d   = CNT_W'(XLEN);
          if (op_i[2]) begin
            mcand_d = bMag;
            acc_d   = {{XLEN{1'b0}}, aMag};
          end else begin
            mcand_d = aMag;
            acc_d   = {{XLEN{1'b0}}, bMag};
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? divStep : mulStep;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          result_d = fixWord;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including the held result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Outputs decode only registered state, so no input reaches them
  // combinationally.
  assign busy_o   = (state_q == CALC) || (state_q == FIX);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq
// Self-checking bench for mul_div_seq (XLEN=32). A timing/arithmetic model
// predicts busy, done and result each cycle; directed vectors also compare
// the result against hand-computed constants at each done pulse.

module tb_mul_div_seq;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  int checks   = 0;
  int failures = 0;

  mul_div_seq dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .kill_i  (kill),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference written straight from the RV32M rules with wide
  // integer arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, uy, ps;
    logic [63:0] pu;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    r  = '0;
    case (f)
      3'b000: begin pu = {32'd0, x} * {32'd0, y}; r = pu[31:0]; end
      3'b001: begin ps = sx * sy; r = ps[63:32]; end
      3'b010: begin ps = sx * uy; r = ps[63:32]; end
      3'b011: begin pu = {32'd0, x} * {32'd0, y}; r = pu[63:32]; end
      3'b100: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(x) / $signed(y);
      end
      3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Model: modelAge counts cycles since accept (0 = idle). Busy covers ages
  // 1..XLEN+1, the done cycle is age XLEN+2, and the result appears with it.
  int          modelAge;
  logic [31:0] modelResult;
  logic [2:0]  pendOp;
  logic [31:0] pendA, pendB;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelAge    <= 0;
      modelResult <= '0;
      pendOp      <= '0;
      pendA       <= '0;
      pendB       <= '0;
    end else if (modelAge == 0) begin
      if (start && !kill) begin
        modelAge <= 1;
        pendOp   <= op;
        pendA    <= a;
        pendB    <= b;
      end
    end else if (modelAge == LAT) begin
      modelAge <= 0;
    end else if (kill) begin
      modelAge <= 0;
    end else if (modelAge == LAT - 1) begin
      modelAge    <= LAT;
      modelResult <= refResult(pendOp, pendA, pendB);
    end else begin
      modelAge <= modelAge + 1;
    end
  end

  // Per-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy_o !== (modelAge >= 1 && modelAge <= LAT - 1)) begin
        failures++;
        $display("[TB] FAIL cycle busy: got %b expected %b (age %0d)", busy_o, (modelAge >= 1 && modelAge <= LAT - 1), modelAge);
      end
      checks++;
      if (done_o !== (modelAge == LAT)) begin
        failures++;
        $display("[TB] FAIL cycle done: got %b expected %b (age %0d)", done_o, (modelAge == LAT), modelAge);
      end
      checks++;
      if (result_o !== modelResult) begin
        failures++;
        $display("[TB] FAIL cycle result: got %h expected %h", result_o, modelResult);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one op, wait (bounded) for done, then check latency, the result
  // against a hand-computed constant, and the single-cycle done pulse.
  task automatic applyStimulus(input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV,
                               input logic [31:0] expV, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = opV; a = aV; b = bV;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_o) seen = 1'b1;
    end
    checkOutput({name, " done seen"}, {31'd0, seen}, 32'd1);
    checkOutput({name, " latency"}, lat, LAT);
    checkOutput({name, " result"}, result_o, expV);
    @(posedge clk);
    #1;
    checkOutput({name, " done width"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    bit sawDone;
    int lat;
    bit seen;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;

    // Pin the reference model with hand-worked values.
    checkOutput("model MULH", refResult(3'b001, 32'hFFFF_FFFF, 32'h2), 32'hFFFF_FFFF);
    checkOutput("model MULHSU", refResult(3'b010, 32'hFFFF_FFFF, 32'h2), 32'hFFFF_FFFF);
    checkOutput("model REM", refResult(3'b110, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
    checkOutput("model DIV ovf", refResult(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset done", {31'd0, done_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    rst_n = 1'b1;

    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, "MUL");

    // Reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("midreset done", {31'd0, done_o}, 32'd0);
    checkOutput("midreset result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, "MUL 3*4");

    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, "MULH");
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, "MULHU");
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, "MULHSU");
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH minmin");

    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2");
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7%2");
    applyStimulus(3'b101, 32'd7, 32'd2, 32'd3, "DIVU 7/2");
    applyStimulus(3'b111, 32'd7, 32'd2, 32'd1, "REMU 7%2");
    applyStimulus(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "DIV 100/-7");

    applyStimulus(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIV by0");
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "REM by0");
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "REM ovf");
    applyStimulus(3'b111, 32'd5, 32'd0, 32'd5, "REMU by0");

    // Kill at cycle 20 of a DIV: no done, result kept, then a fresh start.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("kill busy", {31'd0, busy_o}, 32'd0);
    checkOutput("kill done", {31'd0, done_o}, 32'd0);
    checkOutput("kill result", result_o, 32'd5);
    @(negedge clk);
    kill = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) sawDone = 1'b1;
    end
    checkOutput("kill no done", {31'd0, sawDone}, 32'd0);
    applyStimulus(3'b100, 32'd100, 32'd7, 32'd14, "DIV after kill");

    // kill in IDLE blocks a same-cycle start.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1;
    checkOutput("kill blocks start", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;

    // start held high: second op accepted only in the IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'h8000_0001; b = 32'd6;
    @(posedge clk);
    lat = 1; seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_o) seen = 1'b1;
    end
    checkOutput("held done seen", {31'd0, seen}, 32'd1);
    checkOutput("held latency", lat, LAT);
    checkOutput("held result", result_o, 32'd3);
    @(posedge clk);
    #1;
    checkOutput("held idle busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held reaccept busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_o) seen = 1'b1;
    end
    checkOutput("held second latency", lat, LAT);
    checkOutput("held second result", result_o, 32'd3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
